// File: rtl/lc4_div_seq_if.sv
// Request/result handshake bundle for the LC4 DIV/MOD sequencer.
// master = requester/consumer side, slave = the sequencer.
interface lc4_div_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_busy;

    modport master (
        output i_valid, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_busy
    );

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_busy
    );
endinterface

// File: rtl/lc4_div_seq.sv
// Restoring shift-subtract unsigned divider for LC4 DIV/MOD, one quotient bit per cycle.
// Optional LC4_DIV_EARLY_EXIT_EN: divide-by-zero and dividend < divisor skip CALC.
//
// state | meaning
// IDLE  | o_ready high, waiting for a request
// CALC  | one restoring step per cycle, WIDTH steps total
// DONE  | o_valid high, result held until i_ready
module lc4_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    lc4_div_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic             div_zero;
    logic             ready;
    logic             valid;
    logic             busy;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // The stored partial remainder is always < divisor, so it fits in WIDTH bits;
    // only the shifted value needs the extra bit for the compare/subtract.
    logic [WIDTH:0]   r_sh;
    logic             r_ge;
    logic [WIDTH:0]   r_sub;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        r_ge  = (r_sh >= {1'b0, divisor});
        r_sub = r_sh - {1'b0, divisor};
        r_nx  = r_ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_nx  = {q[WIDTH-2:0], r_ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            valid     <= 1'b0;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            q         <= '0;
            r         <= '0;
            divisor   <= '0;
            cnt       <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        divisor  <= bus.i_divisor;
                        q        <= bus.i_dividend;
                        r        <= '0;
                        cnt      <= '0;
                        div_zero <= (bus.i_divisor == '0);
                        ready    <= 1'b0;
                        busy     <= 1'b1;
`ifdef LC4_DIV_EARLY_EXIT_EN
                        if ((bus.i_divisor == '0) || (bus.i_dividend < bus.i_divisor)) begin
                            state     <= DONE;
                            valid     <= 1'b1;
                            quotient  <= '0;
                            remainder <= (bus.i_divisor == '0) ? '0 : bus.i_dividend;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    q   <= q_nx;
                    r   <= r_nx;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        valid     <= 1'b1;
                        // LC4 defines x/0 and x%0 as zero; override the datapath result
                        quotient  <= div_zero ? '0 : q_nx;
                        remainder <= div_zero ? '0 : r_nx;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid;
    assign bus.o_busy      = busy;
    assign bus.o_quotient  = quotient;
    assign bus.o_remainder = remainder;
endmodule
